// File: rtl/rv_inst_encoder_if.sv
// Handshake bundle for the RV32 instruction encoder: decoded fields in, packed
// and address-tagged instruction words out.
interface rv_inst_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        imm_sel;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              base_load;
    logic [ADDR_W-1:0] base_addr;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;

    modport master (
        output in_valid, imm_sel, opcode, rd, rs1, rs2, funct3, funct7, imm,
               base_load, base_addr, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, out_err
    );

    modport slave (
        input  in_valid, imm_sel, opcode, rd, rs1, rs2, funct3, funct7, imm,
               base_load, base_addr, out_ready,
        output in_ready, out_valid, out_inst, out_addr, out_err
    );
endinterface

// File: rtl/rv_inst_encoder.sv
// Streaming RV32 instruction encoder: packs decoded fields and a full immediate
// into an instruction word, flags unencodable immediates, tags words with addresses.
module rv_inst_encoder #(
    parameter int ADDR_W   = 32,
    parameter int ERRCNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    rv_inst_encoder_if.slave    bus,
    output logic [ERRCNT_W-1:0] err_count
);
    typedef enum logic [2:0] {
        SEL_I = 3'd0,
        SEL_S = 3'd1,
        SEL_B = 3'd2,
        SEL_U = 3'd3,
        SEL_J = 3'd4,
        SEL_R = 3'd5
    } imm_sel_e;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       enc_inst;
    logic              enc_err;
    logic              accept;
    logic              fits_12;
    logic              fits_13;
    logic              fits_21;
    logic [31:0]       imm;

    assign imm = bus.imm;

    // An immediate fits N signed bits when every bit from N-1 upward matches.
    assign fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits_13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits_21 = (&imm[31:20]) | ~(|imm[31:20]);

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign word_addr    = bus.base_load ? bus.base_addr : addr_q;

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a value held (no latch).
        enc_inst = '0;
        enc_err  = 1'b0;
        case (bus.imm_sel)
            SEL_I: begin
                enc_inst = {imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
                enc_err  = !fits_12;
            end
            SEL_S: begin
                enc_inst = {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], bus.opcode};
                enc_err  = !fits_12;
            end
            SEL_B: begin
                enc_inst = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                            imm[4:1], imm[11], bus.opcode};
                enc_err  = !fits_13 || imm[0];
            end
            SEL_U: begin
                enc_inst = {imm[31:12], bus.rd, bus.opcode};
                enc_err  = |imm[11:0];
            end
            SEL_J: begin
                enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, bus.opcode};
                enc_err  = !fits_21 || imm[0];
            end
            SEL_R: begin
                enc_inst = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            end
            default: begin
                enc_err = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_inst  <= '0;
            bus.out_addr  <= '0;
            bus.out_err   <= 1'b0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_inst  <= enc_inst;
            bus.out_addr  <= word_addr;
            bus.out_err   <= enc_err;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    // A same-cycle base_load retargets the accepted word itself, not just the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else if (accept) begin
            addr_q <= word_addr + ADDR_W'(4);
        end else if (bus.base_load) begin
            addr_q <= bus.base_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (accept && enc_err && !(&err_count)) begin
            err_count <= err_count + ERRCNT_W'(1);
        end
    end
endmodule

// File: tb/tb_rv_inst_encoder.sv
// Directed bench for rv_inst_encoder: hand-encoded vectors, backpressure, address
// wrap, mid-stream reset, immediate round-trip and error-counter saturation.
module tb_rv_inst_encoder;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] err_count;
    int          vectors     = 0;
    int          miscompares = 0;

    rv_inst_encoder_if #(.ADDR_W(32)) bus ();

    rv_inst_encoder #(.ADDR_W(32), .ERRCNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input logic [2:0] sel, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm);
        bus.in_valid = 1'b1;
        bus.imm_sel  = sel;
        bus.opcode   = op;
        bus.rd       = rd;
        bus.rs1      = rs1;
        bus.rs2      = rs2;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.imm      = imm;
    endtask

    // One accept with out_ready high, then check the registered word.
    task automatic xfer(input string tag, input logic [2:0] sel, input logic [6:0] op,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] exp_inst, input logic exp_err, input logic [31:0] exp_addr);
        set_fields(sel, op, rd, rs1, rs2, f3, f7, imm);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_inst"},  64'(bus.out_inst),  64'(exp_inst));
        check({tag, "_err"},   64'(bus.out_err),   64'(exp_err));
        check({tag, "_addr"},  64'(bus.out_addr),  64'(exp_addr));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Immediate generator as used by the decode stage.
    function automatic logic [31:0] decode_imm(input logic [2:0] sel, input logic [31:0] i);
        case (sel)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {i[31:12], 12'b0};
            3'd4:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        logic [31:0] r;
        logic [31:0] rimm;
        logic [2:0]  rsel;
        logic [6:0]  rop;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.base_load = 1'b0;
        bus.base_addr = '0;
        set_fields(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_inst",  64'(bus.out_inst),  64'd0);
        check("rst_out_addr",  64'(bus.out_addr),  64'd0);
        check("rst_out_err",   64'(bus.out_err),   64'd0);
        check("rst_err_count", 64'(err_count),     64'd0);

        // Hand-encoded vectors; addresses step by 4 from 0.
        xfer("i_addi",  3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,          32'h00500093, 1'b0, 32'd0);
        xfer("b_neg4",  3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC,   32'hFE000EE3, 1'b0, 32'd4);
        xfer("b_odd",   3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,          32'h00000163, 1'b1, 32'd8);
        check("errcnt_1", 64'(err_count), 64'd1);
        xfer("u_lui",   3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000,   32'h123452B7, 1'b0, 32'd12);
        xfer("j_jal",   3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800,   32'h001000EF, 1'b0, 32'd16);
        xfer("i_2048",  3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,       32'h80000093, 1'b1, 32'd20);
        xfer("s_sw",    3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,          32'h0020A423, 1'b0, 32'd24);
        xfer("r_sub",   3'd5, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEADBEEF,  32'h402081B3, 1'b0, 32'd28);
        xfer("illegal", 3'd6, 7'h13, 5'd1, 5'd1, 5'd1, 3'd7, 7'h7F, 32'd0,         32'h00000000, 1'b1, 32'd32);
        xfer("u_low",   3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001,   32'h123452B7, 1'b1, 32'd36);
        xfer("i_min",   3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800,   32'h80000093, 1'b0, 32'd40);
        check("errcnt_4", 64'(err_count), 64'd4);
        @(negedge clk);
        check("drain_valid", 64'(bus.out_valid), 64'd0);

        // Backpressure: three words, sink stalled for four cycles.
        do_reset();
        bus.out_ready = 1'b0;
        set_fields(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        @(negedge clk);
        set_fields(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        for (int k = 0; k < 4; k++) begin
            check("bp_hold_inst",  64'(bus.out_inst),  64'h00100093);
            check("bp_hold_addr",  64'(bus.out_addr),  64'd0);
            check("bp_in_ready",   64'(bus.in_ready),  64'd0);
            check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        check("bp_w1_inst", 64'(bus.out_inst), 64'h00200093);
        check("bp_w1_addr", 64'(bus.out_addr), 64'd4);
        set_fields(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_w2_inst", 64'(bus.out_inst), 64'h00300093);
        check("bp_w2_addr", 64'(bus.out_addr), 64'd8);
        @(negedge clk);
        check("bp_empty", 64'(bus.out_valid), 64'd0);

        // base_load without an accept retargets the next word.
        bus.base_load = 1'b1;
        bus.base_addr = 32'h00000100;
        @(negedge clk);
        bus.base_load = 1'b0;
        xfer("bl_idle", 3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0, 32'h100);

        // base_load with a simultaneous accept, then wrap through zero.
        bus.base_load = 1'b1;
        bus.base_addr = 32'hFFFFFFF8;
        set_fields(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        @(negedge clk);
        bus.base_load = 1'b0;
        bus.base_addr = 32'h0;
        check("wrap_a0", 64'(bus.out_addr), 64'hFFFFFFF8);
        @(negedge clk);
        check("wrap_a1", 64'(bus.out_addr), 64'hFFFFFFFC);
        @(negedge clk);
        check("wrap_a2", 64'(bus.out_addr), 64'h00000000);
        bus.imm_sel = 3'd7;
        @(negedge clk);
        check("pre_rst_errcnt", 64'(err_count), 64'd1);

        // Reset mid-stream with a word held.
        bus.out_ready = 1'b0;
        bus.imm_sel   = 3'd0;
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("mid_rst_valid",  64'(bus.out_valid), 64'd0);
        check("mid_rst_errcnt", 64'(err_count),     64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 64'(bus.out_valid), 64'd0);
        xfer("post_rst", 3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0, 32'd0);

        // Round-trip: legal immediates per format decode back exactly.
        for (int n = 0; n < 300; n++) begin
            r    = $urandom;
            rsel = 3'($urandom_range(0, 4));
            rop  = 7'($urandom);
            case (rsel)
                3'd0, 3'd1: rimm = {{20{r[11]}}, r[11:0]};
                3'd2:       rimm = {{19{r[12]}}, r[12:1], 1'b0};
                3'd3:       rimm = {r[31:12], 12'b0};
                default:    rimm = {{11{r[20]}}, r[20:1], 1'b0};
            endcase
            set_fields(rsel, rop, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), rimm);
            @(negedge clk);
            bus.in_valid = 1'b0;
            check("rt_imm", 64'(decode_imm(rsel, bus.out_inst)), 64'(rimm));
            check("rt_err", 64'(bus.out_err), 64'd0);
            check("rt_op",  64'(bus.out_inst[6:0]), 64'(rop));
        end
        check("rt_errcnt", 64'(err_count), 64'd0);

        // Error counter saturation with a continuous stream of illegal words.
        set_fields(3'd7, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (65534) @(negedge clk);
        check("sat_fffe", 64'(err_count), 64'hFFFE);
        repeat (3) @(negedge clk);
        check("sat_ffff", 64'(err_count), 64'hFFFF);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("sat_hold", 64'(err_count), 64'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
